// File: rtl/tp_wb_addr_gen_pkg.sv
// Shared definitions for the TP-lane transpose writeback address generator:
// default geometry, derived constants, FSM encoding and lane packing helper.
package tp_wb_addr_gen_pkg;

   // Default geometry of the four-step NTT TP lane
   localparam int DEF_N       = 128;
   localparam int DEF_SIZE0   = 16;
   localparam int DEF_SIZE1   = 8;
   localparam int DEF_TP      = 8;
   localparam int DEF_BTF_LAT = 8;

   // Derived constants for the default geometry
   localparam int DEF_DEPTH = DEF_N / DEF_TP;
   localparam int DEF_W     = $clog2(DEF_DEPTH) + 1;
   localparam int DEF_S     = DEF_SIZE1 / DEF_TP;
   localparam int DEF_LS    = $clog2(DEF_S);
   localparam int DEF_Z     = DEF_SIZE0 / DEF_TP;

   // Pass sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Lane 0 occupies the most significant W bits of a packed address bus;
   // returns the LSB position of the given lane.
   function automatic int lane_lsb(input int lane, input int w, input int tp);
      return (tp - 1 - lane) * w;
   endfunction

endpackage

// File: rtl/tp_perm_addr.sv
// Combinational transpose scatter: maps result row k to per-lane bank
// addresses using the stride formula and a per-row lane rotation.
// The bank half written is the opposite of the one being read.
module tp_perm_addr
   import tp_wb_addr_gen_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int SIZE0 = DEF_SIZE0,
   parameter int SIZE1 = DEF_SIZE1,
   parameter int TP    = DEF_TP
) (
   input  logic [$clog2(N/TP)-1:0]          k,
   input  logic                             bank,
   output logic [($clog2(N/TP)+1)*TP-1:0]   addr
);

   localparam int DEPTH = N / TP;
   localparam int KW    = $clog2(DEPTH);
   localparam int W     = KW + 1;
   localparam int S     = SIZE1 / TP;
   localparam int LS    = $clog2(S);
   localparam int Z     = SIZE0 / TP;
   localparam int L1    = $clog2(SIZE1);

   int              lane;
   logic [KW-1:0]   a;

   // Scatter each source index i to its rotated lane; sums are formed at
   // full integer width and reduced mod depth only by the final size cast.
   always_comb begin
      addr = '0;
      lane = 0;
      a    = '0;
      for (int i = 0; i < TP; i++) begin
         lane = (i + ((int'(k) >> LS) & (TP - 1))) & (TP - 1);
         a    = KW'(Z * S * i + Z * (int'(k) & (S - 1)) + (int'(k) >> L1));
         addr[lane_lsb(lane, W, TP) +: W] = {~bank, a};
      end
   end

endmodule

// File: rtl/tp_wb_addr_gen.sv
// Transpose writeback address generator: linear row reads from one bank
// half, transposed/rotated row writes to the other half BTF_LAT cycles
// later, ping-pong half swap at the end of every completed pass.
module tp_wb_addr_gen
   import tp_wb_addr_gen_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int SIZE0   = DEF_SIZE0,
   parameter int SIZE1   = DEF_SIZE1,
   parameter int TP      = DEF_TP,
   parameter int BTF_LAT = DEF_BTF_LAT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic [($clog2(N/TP)+1)*TP-1:0]   read_addr,
   output logic                             read_en,
   output logic [($clog2(N/TP)+1)*TP-1:0]   write_addr,
   output logic                             write_en,
   output logic                             busy,
   output logic                             done
);

   localparam int            DEPTH  = N / TP;
   localparam int            KW     = $clog2(DEPTH);
   localparam int            W      = KW + 1;
   localparam logic [KW-1:0] LAST_K = KW'(DEPTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic              bank;
   logic [KW-1:0]     rd_k;
   logic [BTF_LAT-1:0] vld_dly;
   logic [KW-1:0]     k_dly [BTF_LAT];
   logic              wr_vld;
   logic [KW-1:0]     wr_k;
   logic [W*TP-1:0]   perm_addr;

   assign wr_vld = vld_dly[BTF_LAT-1];
   assign wr_k   = k_dly[BTF_LAT-1];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and status outputs; start is only honoured in IDLE
   always_comb begin
      state_nxt = state;
      read_en   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            read_en = 1'b1;
            busy    = 1'b1;
            if (rd_k == LAST_K) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (wr_vld && (wr_k == LAST_K)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read row counter (wraps to 0 after the last row) and ping-pong half
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_k <= '0;
         bank <= 1'b0;
      end else begin
         if (state == ST_RUN) begin
            rd_k <= rd_k + 1'b1;
         end else begin
            rd_k <= '0;
         end
         if (state == ST_DONE) begin
            bank <= ~bank;
         end
      end
   end

   // Butterfly latency delay line carrying (valid, row) from read to write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_dly <= '0;
         for (int i = 0; i < BTF_LAT; i++) k_dly[i] <= '0;
      end else begin
         vld_dly[0] <= read_en;
         k_dly[0]   <= rd_k;
         for (int i = 1; i < BTF_LAT; i++) begin
            vld_dly[i] <= vld_dly[i-1];
            k_dly[i]   <= k_dly[i-1];
         end
      end
   end

   tp_perm_addr #(
      .N     (N),
      .SIZE0 (SIZE0),
      .SIZE1 (SIZE1),
      .TP    (TP)
   ) u_perm (
      .k    (wr_k),
      .bank (bank),
      .addr (perm_addr)
   );

   // Address buses are held at zero while their enable is low
   always_comb begin
      write_en   = wr_vld;
      read_addr  = read_en ? {TP{{bank, rd_k}}} : '0;
      write_addr = wr_vld ? perm_addr : '0;
   end

endmodule

// File: tb/tb_tp_wb_addr_gen.sv
// Scoreboard bench: three generators (BTF_LAT 8, 1, 20) share clock, reset
// and start; accepted passes push the expected read/write rows, which are
// popped and compared as the DUTs present them.
`timescale 1ns/1ps
module tb_tp_wb_addr_gen;

   localparam int TP    = 8;
   localparam int DEPTH = 16;
   localparam int W     = 5;
   localparam int AW    = W * TP;
   localparam int SZ1   = 8;
   localparam int S     = 1;
   localparam int Z     = 2;

   typedef struct {
      int              cyc;
      int              k;
      logic            bank;
      logic [AW-1:0]   addr;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   logic [AW-1:0] ra [3];
   logic [AW-1:0] wa [3];
   logic          ren [3];
   logic          wen [3];
   logic          bsy [3];
   logic          dn  [3];

   int            lat [3] = '{8, 1, 20};
   item_t         rq [3][$];
   item_t         wq [3][$];
   int            pass_e [3];
   int            idle_from [3];
   logic          bank_m [3];
   logic [15:0]   seen [3][8];

   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;
   item_t         it_m;
   logic          busy_x, done_x;
   int            e_b, e_c;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tp_wb_addr_gen #(.BTF_LAT(8)) u0 (
      .clk(clk), .rst(rst), .start(start),
      .read_addr(ra[0]), .read_en(ren[0]), .write_addr(wa[0]),
      .write_en(wen[0]), .busy(bsy[0]), .done(dn[0]));

   tp_wb_addr_gen #(.BTF_LAT(1)) u1 (
      .clk(clk), .rst(rst), .start(start),
      .read_addr(ra[1]), .read_en(ren[1]), .write_addr(wa[1]),
      .write_en(wen[1]), .busy(bsy[1]), .done(dn[1]));

   tp_wb_addr_gen #(.BTF_LAT(20)) u2 (
      .clk(clk), .rst(rst), .start(start),
      .read_addr(ra[2]), .read_en(ren[2]), .write_addr(wa[2]),
      .write_en(wen[2]), .busy(bsy[2]), .done(dn[2]));

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] lane_of(input logic [AW-1:0] v, input int j);
      return v[(TP-j)*W-1 -: W];
   endfunction

   function automatic logic [AW-1:0] rd_exp(input int k, input logic b);
      logic [AW-1:0] r;
      r = '0;
      for (int j = 0; j < TP; j++) r[(TP-j)*W-1 -: W] = {b, 4'(k)};
      return r;
   endfunction

   function automatic logic [AW-1:0] wr_exp(input int k, input logic b);
      logic [AW-1:0] r;
      int a, lane;
      r = '0;
      for (int i = 0; i < TP; i++) begin
         a    = (Z * S * i + Z * (k % S) + k / SZ1) % DEPTH;
         lane = (i + (k / S) % TP) % TP;
         r[(TP-lane)*W-1 -: W] = {~b, 4'(a)};
      end
      return r;
   endfunction

   task automatic reset_model();
      for (int d = 0; d < 3; d++) begin
         rq[d].delete();
         wq[d].delete();
         pass_e[d]    = -1;
         idle_from[d] = 0;
         bank_m[d]    = 1'b0;
      end
   endtask

   task automatic check_quiet(input string tag);
      for (int d = 0; d < 3; d++) begin
         check_val($sformatf("%s u%0d read_addr", tag, d), ra[d], 0);
         check_val($sformatf("%s u%0d read_en", tag, d), ren[d], 0);
         check_val($sformatf("%s u%0d write_addr", tag, d), wa[d], 0);
         check_val($sformatf("%s u%0d write_en", tag, d), wen[d], 0);
         check_val($sformatf("%s u%0d busy", tag, d), bsy[d], 0);
         check_val($sformatf("%s u%0d done", tag, d), dn[d], 0);
      end
   endtask

   // Called at #1 after an edge: start is sampled at the next edge E.
   task automatic pulse_start();
      int e;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      e = cyc;
      for (int d = 0; d < 3; d++) begin
         if (pass_e[d] < 0 && e >= idle_from[d]) begin
            pass_e[d] = e;
            for (int j = 0; j < TP; j++) seen[d][j] = '0;
            for (int k = 0; k < DEPTH; k++) begin
               rq[d].push_back(item_t'{e + k, k, bank_m[d], rd_exp(k, bank_m[d])});
               wq[d].push_back(item_t'{e + k + lat[d], k, bank_m[d], wr_exp(k, bank_m[d])});
            end
         end
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            // read side
            if (ren[d]) begin
               if (rq[d].size() == 0) begin
                  check_val($sformatf("u%0d rd_en_extra", d), ren[d], 0);
               end else begin
                  it_m = rq[d].pop_front();
                  check_val($sformatf("u%0d rd_cycle k%0d", d, it_m.k), cyc, it_m.cyc);
                  check_val($sformatf("u%0d rd_addr k%0d", d, it_m.k), ra[d], it_m.addr);
                  if (d == 0 && it_m.k == 3 && !it_m.bank)
                     check_val("u0 rd_row3_lane0", lane_of(ra[0], 0), 5'd3);
               end
            end else begin
               check_val($sformatf("u%0d rd_addr_idle", d), ra[d], 0);
               if (rq[d].size() != 0 && rq[d][0].cyc <= cyc) begin
                  check_val($sformatf("u%0d rd_en_missing k%0d", d, rq[d][0].k), ren[d], 1);
                  void'(rq[d].pop_front());
               end
            end
            // write side
            if (wen[d]) begin
               if (wq[d].size() == 0) begin
                  check_val($sformatf("u%0d wr_en_extra", d), wen[d], 0);
               end else begin
                  it_m = wq[d].pop_front();
                  check_val($sformatf("u%0d wr_cycle k%0d", d, it_m.k), cyc, it_m.cyc);
                  check_val($sformatf("u%0d wr_addr k%0d", d, it_m.k), wa[d], it_m.addr);
                  for (int j = 0; j < TP; j++) seen[d][j][lane_of(wa[d], j)] = 1'b1;
                  if (d == 0 && !it_m.bank) begin
                     if (it_m.k == 0) begin
                        check_val("u0 wr_row0_lane0", lane_of(wa[0], 0), 5'd16);
                        check_val("u0 wr_row0_lane7", lane_of(wa[0], 7), 5'd30);
                     end
                     if (it_m.k == 1) begin
                        check_val("u0 wr_row1_lane1", lane_of(wa[0], 1), 5'd16);
                        check_val("u0 wr_row1_lane2", lane_of(wa[0], 2), 5'd18);
                        check_val("u0 wr_row1_lane0", lane_of(wa[0], 0), 5'd30);
                     end
                     if (it_m.k == 9) begin
                        check_val("u0 wr_row9_lane1", lane_of(wa[0], 1), 5'd17);
                        check_val("u0 wr_row9_lane0", lane_of(wa[0], 0), 5'd31);
                     end
                  end
               end
            end else begin
               check_val($sformatf("u%0d wr_addr_idle", d), wa[d], 0);
               if (wq[d].size() != 0 && wq[d][0].cyc <= cyc) begin
                  check_val($sformatf("u%0d wr_en_missing k%0d", d, wq[d][0].k), wen[d], 1);
                  void'(wq[d].pop_front());
               end
            end
            // pass status
            busy_x = (pass_e[d] >= 0) && (cyc >= pass_e[d]) && (cyc <= pass_e[d] + DEPTH - 1 + lat[d]);
            done_x = (pass_e[d] >= 0) && (cyc == pass_e[d] + DEPTH + lat[d]);
            check_val($sformatf("u%0d busy", d), bsy[d], busy_x);
            check_val($sformatf("u%0d done", d), dn[d], done_x);
            if (done_x) begin
               for (int j = 0; j < TP; j++)
                  check_val($sformatf("u%0d lane%0d_cover", d, j), seen[d][j], 16'hffff);
               bank_m[d]    = ~bank_m[d];
               idle_from[d] = cyc + 2;
               pass_e[d]    = -1;
            end
         end
      end
   end

   initial begin
      reset_model();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // pass aborted by reset at read row 5
      pulse_start();
      e_b = cyc;
      wait_cyc(e_b + 5);
      #5;
      rst = 1'b1;
      #1;
      check_quiet("mid_pass_reset");
      reset_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // clean pass; stray starts while busy and in u0's done cycle
      pulse_start();
      e_b = cyc;
      wait_cyc(e_b + 4);
      pulse_start();
      wait_cyc(e_b + 24);
      pulse_start();
      wait_cyc(e_b + 70);

      // second pass, then earliest restart right after u0's done cycle
      pulse_start();
      e_c = cyc;
      wait_cyc(e_c + 25);
      pulse_start();
      wait_cyc(e_c + 100);

      // another pass to follow the half swap further
      pulse_start();
      wait_cyc(cyc + 60);

      for (int d = 0; d < 3; d++) begin
         check_val($sformatf("u%0d rd_rows_left", d), rq[d].size(), 0);
         check_val($sformatf("u%0d wr_rows_left", d), wq[d].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tp_wb_addr_gen.md
Name: tp_wb_addr_gen

Overview:
- Writeback-side companion to the transpose read address generator in the TP-lane four-step NTT datapath.
- Reads the TP coefficient banks linearly, one row per cycle.
- After the butterfly pipeline latency, scatters each result row to transposed (permuted) bank addresses with per-lane rotation.
- Ping-pong bank select bit (address MSB) alternates between source and destination half on each completed pass.

Parameters:
- N, 128, transform length (power of two).
- size0, 16, first-dimension size; size0*size1 = N.
- size1, 8, second-dimension size; multiple of TP.
- TP, 8, lanes/banks (power of two).
- BTF_LAT, 8, butterfly pipeline latency in cycles (>=1).
- Derived: depth = N/TP; W = log2(depth)+1; S = size1/TP; LS = log2(S); Z = size0/TP.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pass request.
- read_addr  out  W*TP  per-lane read address; lane i at bits [(TP-i)*W-1 -: W]; MSB = bank half.
- read_en  out  1  read_addr valid.
- write_addr  out  W*TP  per-lane write address, same packing.
- write_en  out  1  write_addr valid.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (async, any time, including mid-pass): all outputs 0; FSM to IDLE; counters 0; bank bit = 0; write delay line cleared. No partial-pass completion.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the read with k = depth-1 is issued.
  - DRAIN -> DONE when the write with k = depth-1 is issued.
  - DONE -> IDLE unconditionally (one cycle).
- start outside IDLE is ignored; no queuing.
- Timing, with start sampled high at edge t0:
  - read row k (0..depth-1) presented at cycle t0+1+k with read_en=1.
  - write row k presented at cycle t0+1+k+BTF_LAT with write_en=1.
  - done=1 at cycle t0+1+depth+BTF_LAT.
  - busy=1 from t0+1 through the last write cycle; busy=0 in the done cycle.
- Read addresses: every lane = {bank, k[W-2:0]} (linear).
- Write addresses, row k:
  - rot = (k>>LS) mod TP.
  - For source index i in 0..TP-1: a_i = (Z*S*i + Z*(k mod S) + (k>>log2(size1))) mod depth.
  - Lane (i+rot) mod TP receives {~bank, a_i}.
- Write k is produced by a BTF_LAT-deep delay line of (valid, k), or by a separate write counter started BTF_LAT cycles after the read counter. Either is acceptable if cycle timing matches exactly.
- Arithmetic: unsigned; all mod operations by power-of-two masks; intermediates must not truncate before masking.
- Bank bit toggles in the DONE cycle only. The next pass reads the half just written.
- Overlap: when BTF_LAT < depth, read and write phases overlap; read_en and write_en may be high simultaneously.
- Outputs are zero whenever their enable is low.
- start in the same cycle as the done pulse is ignored. The earliest next start is the cycle after done.
- Bijectivity requirement: across one pass, each lane writes every address 0..depth-1 exactly once.

Decomposition:
- Shared package holds:
  - derived constants depth, W, S, LS, Z;
  - FSM state encodings (IDLE, RUN, DRAIN, DONE);
  - lane-slice helper function for the packing.
- One natural sub-module, tp_perm_addr: combinational (k, bank) -> packed write_addr using the rotate/stride formula, reusable by other transpose stages.
- Delay line stays inline.

Test Plan:
- Reset/idle: assert rst mid-RUN at row 5 -> all outputs 0 immediately; bank=0; busy=0; no done; a subsequent start gives a full clean pass.
- Basic pass, defaults (depth=16, W=5), start at t0:
  - read_en high cycles t0+1..t0+16; row k=3 reads {0,3} on all lanes.
  - write row 0 at t0+9: lane j = {1, 2j}, i.e. lane0=16, lane7=30.
  - done at t0+25.
- Rotation:
  - row k=1: lane1={1,0}=16, lane2=18, ..., lane0={1,14}=30.
  - row k=9: lane1={1,1}=17, lane0={1,15}=31.
- Ping-pong: second pass after done -> reads carry MSB=1, writes MSB=0; third pass back to read MSB=0.
- start ignored: pulse start at t0+4 and in the done cycle -> no extra pass; busy and timing unchanged.
- Coverage: for each lane, collect write addresses over one pass -> exactly {0..15}, each once. Repeat with BTF_LAT=1 and BTF_LAT=20 (no overlap) -> timing formulas hold.
